// File: rtl/record_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : record_assembler
//  Description : Assembles {x, y, z} records from field-indexed beats, filling
//                fields missing at an early close with parameterised defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
module record_assembler #(
    parameter logic [7:0]  DEF_BYTE = 8'd0,
    parameter logic [31:0] DEF_INT  = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_idx,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [47:0] out_rec,
    output logic        err,
    output logic [15:0] rec_count
);

    localparam logic [1:0] c_IDX_X   = 2'd0;
    localparam logic [1:0] c_IDX_Y   = 2'd1;
    localparam logic [1:0] c_IDX_Z   = 2'd2;
    localparam logic [1:0] c_IDX_BAD = 2'd3;

    logic [7:0]  r_acc_x;
    logic [7:0]  r_acc_y;
    logic [31:0] r_acc_z;
    logic [2:0]  r_have;
    logic [47:0] r_out_rec;
    logic        r_out_valid;
    logic        r_err;
    logic [15:0] r_rec_count;

    logic        w_accept;
    logic        w_wr_x;
    logic        w_wr_y;
    logic        w_wr_z;
    logic        w_bad;
    logic        w_xfer;
    logic        w_close;
    logic [2:0]  w_have_next;
    logic [7:0]  w_x_next;
    logic [7:0]  w_y_next;
    logic [31:0] w_z_next;
    logic [47:0] w_record;

    // Conservative: any beat stalls while an undelivered record is held.
    assign in_ready = !rst && (!r_out_valid || out_ready);
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_out_valid && out_ready;

    assign w_wr_x = w_accept && (in_idx == c_IDX_X);
    assign w_wr_y = w_accept && (in_idx == c_IDX_Y);
    assign w_wr_z = w_accept && (in_idx == c_IDX_Z);
    assign w_bad  = w_accept && (in_idx == c_IDX_BAD);

    // Next-state views include the current beat so a closing beat's own field lands in the record.
    assign w_x_next    = w_wr_x ? in_data[7:0] : r_acc_x;
    assign w_y_next    = w_wr_y ? in_data[7:0] : r_acc_y;
    assign w_z_next    = w_wr_z ? in_data     : r_acc_z;
    assign w_have_next = r_have | {w_wr_z, w_wr_y, w_wr_x};

    assign w_close  = w_accept && ((w_have_next == 3'b111) || in_last);
    assign w_record = {w_have_next[0] ? w_x_next : DEF_BYTE,
                       w_have_next[1] ? w_y_next : DEF_BYTE,
                       w_have_next[2] ? w_z_next : DEF_INT};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc_x     <= 8'd0;
            r_acc_y     <= 8'd0;
            r_acc_z     <= 32'd0;
            r_have      <= 3'b000;
            r_out_rec   <= 48'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rec_count <= 16'd0;
        end else begin
            r_acc_x <= w_x_next;
            r_acc_y <= w_y_next;
            r_acc_z <= w_z_next;
            r_err   <= w_bad;

            if (w_close) begin
                r_have      <= 3'b000;
                r_out_rec   <= w_record;
                r_out_valid <= 1'b1;
            end else begin
                r_have <= w_have_next;
                if (w_xfer) begin
                    r_out_valid <= 1'b0;
                end
            end

            if (w_xfer) begin
                r_rec_count <= r_rec_count + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_rec   = r_out_rec;
    assign err       = r_err;
    assign rec_count = r_rec_count;

endmodule
`default_nettype wire
